// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of signals around mem_port_arbiter. It covers the
//               core's fetch port (I*), its load/store port (D*), the
//               single-port memory request/response (R*) and status
//               (Busy/Err).
//   modport slave  : the arbiter's view. It takes requests from the core
//                    and responses from the memory, and it drives
//                    completions, the memory request and status.
//   modport master : the environment's view (core + memory model).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // instruction-fetch port
    logic          IRdy;
    logic [AW-1:0] IAddr;
    logic          IVld;
    logic [DW-1:0] IData;
    // load/store port
    logic          DRdy;
    logic [AW-1:0] DAddr;
    logic [DW-1:0] DWData;
    logic          DWEn;
    logic          DVld;
    logic [DW-1:0] DData;
    // memory side
    logic          RRdy;
    logic [AW-1:0] RAddr;
    logic [DW-1:0] RWData;
    logic          RWEn;
    logic          RVld;
    logic [DW-1:0] RData;
    // status
    logic          Busy;
    logic          Err;

    modport slave (
        input  IRdy, IAddr, DRdy, DAddr, DWData, DWEn, RVld, RData,
        output IVld, IData, DVld, DData, RRdy, RAddr, RWData, RWEn, Busy, Err
    );

    modport master (
        output IRdy, IAddr, DRdy, DAddr, DWData, DWEn, RVld, RData,
        input  IVld, IData, DVld, DData, RRdy, RAddr, RWData, RWEn, Busy, Err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between the core's fetch port
//               (I*) and load/store port (D*). Transactions are handled one
//               at a time by an IDLE -> REQ -> DONE state machine. RRdy drops
//               for at least the DONE cycle after every RVld. A request that
//               waits TIMEOUT REQ cycles without RVld is aborted with Err.
// Ports       : clk   - clock, posedge
//               rstn  - synchronous active-low reset
//               bus   - mem_port_arbiter_if.slave (I*, D*, R*, Busy, Err)
// Parameters  : AW, DW  - address / data width (must match the interface)
//               TIMEOUT - REQ cycles without RVld before abort, 0 = never
// Build macro : ARB_ROUND_ROBIN_EN - when defined, a D/I tie goes to the port
//               that did not win the previous grant. When undefined, D always
//               beats I.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // The counter only needs to reach TIMEOUT-1.
    localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam bit                 c_TO_EN    = (TIMEOUT != 0);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_gnt_d;   // winner of the current transaction: 1 = D, 0 = I
    logic               r_is_wr;   // current transaction is a store

    // registered outputs
    logic               r_rrdy;
    logic [AW-1:0]      r_raddr;
    logic [DW-1:0]      r_rwdata;
    logic               r_rwen;
    logic               r_ivld;
    logic [DW-1:0]      r_idata;
    logic               r_dvld;
    logic [DW-1:0]      r_ddata;
    logic               r_busy;
    logic               r_err;

    logic               w_req_any;
    logic               w_gnt_d;
    logic               w_timeout;
    logic               w_finish;
    logic [DW-1:0]      w_done_data;

    assign w_req_any = bus.DRdy | bus.IRdy;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D won the last grant. It resets to I, so D wins the first tie.
    logic r_last_d;

    assign w_gnt_d = bus.DRdy & (~bus.IRdy | ~r_last_d);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_last_d <= 1'b0;
        end else if (r_state == c_IDLE && w_req_any) begin
            r_last_d <= w_gnt_d;
        end
    end
`else
    assign w_gnt_d = bus.DRdy;
`endif

    // RVld takes precedence over a timeout that expires in the same cycle.
    assign w_timeout   = c_TO_EN && (r_cnt == c_CNT_LAST) && !bus.RVld;
    assign w_finish    = bus.RVld || w_timeout;
    // Stores and aborted requests report zero data.
    assign w_done_data = (bus.RVld && !r_is_wr) ? bus.RData : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_gnt_d  <= 1'b0;
            r_is_wr  <= 1'b0;
            r_rrdy   <= 1'b0;
            r_raddr  <= '0;
            r_rwdata <= '0;
            r_rwen   <= 1'b0;
            r_ivld   <= 1'b0;
            r_idata  <= '0;
            r_dvld   <= 1'b0;
            r_ddata  <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req_any) begin
                        r_state <= c_REQ;
                        r_cnt   <= '0;
                        r_gnt_d <= w_gnt_d;
                        r_rrdy  <= 1'b1;
                        r_busy  <= 1'b1;
                        if (w_gnt_d) begin
                            r_raddr  <= bus.DAddr;
                            r_rwdata <= bus.DWData;
                            r_rwen   <= bus.DWEn;
                            r_is_wr  <= bus.DWEn;
                        end else begin
                            // Fetches leave RWData at its last value; it is
                            // meaningless without RWEn.
                            r_raddr <= bus.IAddr;
                            r_rwen  <= 1'b0;
                            r_is_wr <= 1'b0;
                        end
                    end
                end

                c_REQ: begin
                    // The write strobe lasts only for the first REQ cycle.
                    r_rwen <= 1'b0;
                    if (w_finish) begin
                        r_state <= c_DONE;
                        r_rrdy  <= 1'b0;
                        r_cnt   <= '0;
                        r_err   <= w_timeout;
                        if (r_gnt_d) begin
                            r_dvld  <= 1'b1;
                            r_ddata <= w_done_data;
                        end else begin
                            r_ivld  <= 1'b1;
                            r_idata <= w_done_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_DONE: begin
                    // Requests are not sampled here. The requester drops Rdy
                    // at the end of this cycle.
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_ivld  <= 1'b0;
                    r_idata <= '0;
                    r_dvld  <= 1'b0;
                    r_ddata <= '0;
                    r_err   <= 1'b0;
                end

                default: begin
                    r_state <= c_IDLE;
                    r_rrdy  <= 1'b0;
                    r_rwen  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ivld  <= 1'b0;
                    r_dvld  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RRdy   = r_rrdy;
    assign bus.RAddr  = r_raddr;
    assign bus.RWData = r_rwdata;
    assign bus.RWEn   = r_rwen;
    assign bus.IVld   = r_ivld;
    assign bus.IData  = r_idata;
    assign bus.DVld   = r_dvld;
    assign bus.DData  = r_ddata;
    assign bus.Busy   = r_busy;
    assign bus.Err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter (TIMEOUT = 4).
//               A memory stub answers after a programmable number of REQ
//               cycles. Single transactions come from a vector table. A
//               scoreboard queue holds the expected completions, and a
//               negedge monitor compares each one against the DUT.
//               Hand-written sequences cover port collision and reset in
//               the middle of a transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        bit          is_d;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        bit          mem_en;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_lat;
        int          exp_rrdy;
    } vec_t;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
    } sb_t;

    sb_t  sb[$];
    int   total = 0;
    int   bad   = 0;

    // ---------------- memory stub ----------------
    logic [31:0] mem [0:1023];
    bit          mem_init_done = 1'b0;
    int          mem_delay = 1;     // RVld arrives in REQ cycle mem_delay+1
    bit          mem_en    = 1'b1;  // 0 = never answer
    int          stub_cnt;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int k = 0; k < 1024; k++) mem[k] <= '0;
            mem[10'h040] <= 32'hDEADBEEF;   // address 0x100
            mem_init_done <= 1'b1;
        end
        if (!rstn) begin
            bus.RVld  <= 1'b0;
            bus.RData <= '0;
            stub_cnt  <= 0;
        end else begin
            bus.RVld <= 1'b0;
            if (bus.RRdy && !bus.RVld) begin
                if (bus.RWEn) mem[bus.RAddr[11:2]] <= bus.RWData;
                if (mem_en && stub_cnt == mem_delay - 1) begin
                    bus.RVld  <= 1'b1;
                    bus.RData <= mem[bus.RAddr[11:2]];
                    stub_cnt  <= 0;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end else begin
                stub_cnt <= 0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // The monitor checks completions against the scoreboard, the Busy
    // relation, and that RRdy drops after each RVld.
    bit prev_rvld = 1'b0;
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.IVld || bus.DVld || bus.Err) begin
                chk("completion_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("vld_port", {bus.IVld, bus.DVld}, e.is_d ? 2'b01 : 2'b10);
                    chk("vld_data", e.is_d ? bus.DData : bus.IData, e.data);
                    chk("err", bus.Err, e.err);
                end
            end
            chk("busy", bus.Busy, bus.RRdy | bus.IVld | bus.DVld);
            if (prev_rvld) chk("rrdy_drop_after_rvld", bus.RRdy, 0);
            prev_rvld <= bus.RVld;
        end else begin
            prev_rvld <= 1'b0;
        end
    end

    function automatic vec_t mk(bit is_d, bit wen, logic [31:0] addr, logic [31:0] wdata,
                                int delay, bit men, logic [31:0] exp, bit err, int lat, int rr);
        vec_t v;
        v.is_d = is_d; v.wen = wen; v.addr = addr; v.wdata = wdata;
        v.delay = delay; v.mem_en = men; v.exp_data = exp; v.exp_err = err;
        v.exp_lat = lat; v.exp_rrdy = rr;
        return v;
    endfunction

    // One transaction. Cycle 0 is the cycle in which Rdy is first seen.
    task automatic run_txn(input vec_t v);
        int n, rr, we;
        bit got;
        sb_t e;
        @(negedge clk);
        mem_delay = v.delay;
        mem_en    = v.mem_en;
        if (v.is_d) begin
            bus.DAddr = v.addr; bus.DWData = v.wdata; bus.DWEn = v.wen; bus.DRdy = 1'b1;
        end else begin
            bus.IAddr = v.addr; bus.IRdy = 1'b1;
        end
        e.is_d = v.is_d; e.data = v.exp_data; e.err = v.exp_err;
        sb.push_back(e);
        n = 0; rr = 0; we = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.RRdy) rr++;
            if (bus.RWEn) we++;
            got = v.is_d ? bus.DVld : bus.IVld;
        end
        chk("latency", n, v.exp_lat);
        chk("rrdy_cycles", rr, v.exp_rrdy);
        chk("rwen_cycles", we, v.wen);
        bus.DRdy = 1'b0; bus.IRdy = 1'b0; bus.DWEn = 1'b0;
    endtask

    // Both ports hold their requests until each has had three grants.
    task automatic run_collision();
        bit ord [6];
        int dc, ic, n, last_t;
        sb_t e;
`ifdef ARB_ROUND_ROBIN_EN
        ord = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        ord = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        @(negedge clk);
        mem_delay = 1; mem_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            e.is_d = ord[k];
            e.data = ord[k] ? 32'hCAFEF00D : 32'h12345678;
            e.err  = 1'b0;
            sb.push_back(e);
        end
        bus.DAddr = 32'h100; bus.DWEn = 1'b0; bus.IAddr = 32'h104;
        bus.DRdy = 1'b1; bus.IRdy = 1'b1;
        dc = 0; ic = 0; n = 0; last_t = -1;
        while ((dc < 3 || ic < 3) && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.DVld || bus.IVld) begin
                if (last_t < 0) chk("collide_first_latency", n, 3);
                else            chk("collide_period", n - last_t, 4);
                last_t = n;
            end
            if (bus.DVld) begin dc++; if (dc == 3) bus.DRdy = 1'b0; end
            if (bus.IVld) begin ic++; if (ic == 3) bus.IRdy = 1'b0; end
        end
        chk("collide_d_count", dc, 3);
        chk("collide_i_count", ic, 3);
        bus.DRdy = 1'b0; bus.IRdy = 1'b0;
    endtask

    // A reset asserted during REQ drops the transaction silently.
    task automatic run_reset_mid();
        @(negedge clk);
        mem_delay = 3; mem_en = 1'b1;
        bus.IAddr = 32'h100; bus.IRdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_in_req", bus.RRdy, 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_mid_rrdy",  bus.RRdy,  0);
        chk("rst_mid_busy",  bus.Busy,  0);
        chk("rst_mid_ivld",  bus.IVld,  0);
        chk("rst_mid_dvld",  bus.DVld,  0);
        chk("rst_mid_err",   bus.Err,   0);
        chk("rst_mid_raddr", bus.RAddr, 0);
        bus.IRdy = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    vec_t tbl [10];

    initial begin
        // fetch, store/load pair, store over old data, slow responses,
        // RVld arriving in the timeout cycle, a true timeout, then recovery
        tbl[0] = mk(0, 0, 32'h100, 32'h0,        1, 1, 32'hDEADBEEF, 0, 3, 2);
        tbl[1] = mk(1, 1, 32'h104, 32'h12345678, 1, 1, 32'h0,        0, 3, 2);
        tbl[2] = mk(1, 0, 32'h104, 32'h0,        1, 1, 32'h12345678, 0, 3, 2);
        tbl[3] = mk(0, 0, 32'h104, 32'h0,        1, 1, 32'h12345678, 0, 3, 2);
        tbl[4] = mk(1, 1, 32'h100, 32'hCAFEF00D, 1, 1, 32'h0,        0, 3, 2);
        tbl[5] = mk(0, 0, 32'h100, 32'h0,        1, 1, 32'hCAFEF00D, 0, 3, 2);
        tbl[6] = mk(1, 0, 32'h108, 32'h0,        2, 1, 32'h0,        0, 4, 3);
        tbl[7] = mk(0, 0, 32'h100, 32'h0,        3, 1, 32'hCAFEF00D, 0, 5, 4);
        tbl[8] = mk(0, 0, 32'h200, 32'h0,        1, 0, 32'h0,        1, 5, 4);
        tbl[9] = mk(0, 0, 32'h104, 32'h0,        1, 1, 32'h12345678, 0, 3, 2);

        bus.IRdy = 1'b0; bus.IAddr = '0;
        bus.DRdy = 1'b0; bus.DAddr = '0; bus.DWData = '0; bus.DWEn = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_rrdy",   bus.RRdy,   0);
        chk("reset_rwen",   bus.RWEn,   0);
        chk("reset_raddr",  bus.RAddr,  0);
        chk("reset_rwdata", bus.RWData, 0);
        chk("reset_ivld",   bus.IVld,   0);
        chk("reset_idata",  bus.IData,  0);
        chk("reset_dvld",   bus.DVld,   0);
        chk("reset_ddata",  bus.DData,  0);
        chk("reset_busy",   bus.Busy,   0);
        chk("reset_err",    bus.Err,    0);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        run_collision();
        run_reset_mid();
        run_txn(mk(0, 0, 32'h100, 32'h0, 1, 1, 32'hCAFEF00D, 0, 3, 2));

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
